dma_csr_ctrl: RTL and testbench

AXI4-Lite slave register file that is the host-facing control front end of the DMA engine. It converts CPU register writes into the engine's start/direction/address/length command, and captures completion status and transfer length back into host-readable registers. It also raises a completion interrupt pulse. It sits between Coyote's control AXI-Lite port and the DMA engine's MMIO-controller interface.

---
 rtl/dma_csr_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_dma_csr_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_csr_ctrl.sv
// -----------------------------------------------------------------------------
// dma_csr_ctrl
//
// AXI4-Lite (64-bit data) slave register file. It is the host-facing control
// front end of the DMA engine. CPU writes become a start/direction/address/length
// command for the engine. Engine completion status and the final byte count are
// captured into host-readable registers, and a completion interrupt pulse is
// raised when it is enabled.
//
// Register map (offset = addr[5:3] * 8):
//   0x00 CTRL     bit0 START (write-1-sets, reads pending), bit1 DIR, bit2 IRQ_EN
//   0x08 SRC      RW, VADDR_BITS wide
//   0x10 DST      RW, VADDR_BITS wide
//   0x18 LEN      RW, LEN_BITS wide
//   0x20 STATUS   RO, bit0 DONE, bit1 BUSY
//   0x28 TX_LEN   RO, last captured engine byte count
//   0x30 DONE_CNT RO, 32-bit wrapping completion counter
//   0x38          unmapped, reads 0
//
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*            AXI-Lite write address/data/response channels
//   s_axil_ar*/r*               AXI-Lite read address/data channels
//   dma_start                   command pending to the engine
//   dma_direction               1 = device-to-host
//   dma_src_addr, dma_dst_addr  transfer addresses
//   dma_len                     transfer length in bytes
//   dma_status(_valid)          engine status report (1 = completed)
//   clear_dma_start             engine has accepted the pending command
//   coyote_dma_tx_len(_valid)   final byte count from the engine
//   done_irq                    one-cycle completion pulse (when IRQ_EN)
// -----------------------------------------------------------------------------
module dma_csr_ctrl #(
  parameter int VADDR_BITS     = 48,
  parameter int LEN_BITS       = 28,
  parameter int AXIL_ADDR_BITS = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [AXIL_ADDR_BITS-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [63:0]               s_axil_wdata,
  input  logic [7:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,

  input  logic [AXIL_ADDR_BITS-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [63:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,

  output logic                      dma_start,
  output logic                      dma_direction,
  output logic [VADDR_BITS-1:0]     dma_src_addr,
  output logic [VADDR_BITS-1:0]     dma_dst_addr,
  output logic [LEN_BITS-1:0]       dma_len,
  input  logic                      dma_status,
  input  logic                      dma_status_valid,
  input  logic                      clear_dma_start,
  input  logic                      coyote_dma_tx_len_valid,
  input  logic [LEN_BITS-1:0]       coyote_dma_tx_len,
  output logic                      done_irq
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_SRC      = 3'd1,
    REG_DST      = 3'd2,
    REG_LEN      = 3'd3,
    REG_STATUS   = 3'd4,
    REG_TX_LEN   = 3'd5,
    REG_DONE_CNT = 3'd6,
    REG_UNMAPPED = 3'd7
  } reg_idx_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-lane merge of a write into a zero-extended register image.
  function automatic logic [63:0] f_merge(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [7:0]  strb);
    logic [63:0] v;
    v = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) v[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready, r_rvalid;
  logic [63:0]           r_rdata;

  logic                  r_dma_start;
  logic                  r_dir;
  logic                  r_irq_en;
  logic                  r_busy;
  logic                  r_done;
  logic [VADDR_BITS-1:0] r_src;
  logic [VADDR_BITS-1:0] r_dst;
  logic [LEN_BITS-1:0]   r_len;
  logic [LEN_BITS-1:0]   r_tx_len;
  logic [31:0]           r_done_cnt;
  logic                  r_done_irq;

  // ---------------------------------------------------------------------------
  // Write path decode
  // ---------------------------------------------------------------------------
  reg_idx_e    w_wr_idx;
  logic        w_wr_take;     // both halves present, response slot free
  logic        w_wr_hs;       // address+data accepted this cycle
  logic        w_wr_rw;       // target is a host-writable register
  logic        w_wr_reject;   // writable target, but a transfer is in flight
  logic        w_wr_apply;
  logic        w_start;
  logic        w_completion;
  logic [63:0] w_src_merged, w_dst_merged, w_len_merged;

  assign w_wr_idx    = reg_idx_e'(s_axil_awaddr[5:3]);
  // The !r_awready term keeps the ready a single-cycle pulse even though the
  // master legitimately holds valid high through the handshake cycle.
  assign w_wr_take   = s_axil_awvalid & s_axil_wvalid & ~r_bvalid & ~r_awready;
  assign w_wr_hs     = r_awready & s_axil_awvalid & s_axil_wvalid;
  assign w_wr_rw     = (w_wr_idx == REG_CTRL) || (w_wr_idx == REG_SRC) ||
                       (w_wr_idx == REG_DST)  || (w_wr_idx == REG_LEN);
  // BUSY is sampled at the handshake, so a completion landing in the same
  // cycle does not rescue the write.
  assign w_wr_reject = w_wr_hs & w_wr_rw & r_busy;
  assign w_wr_apply  = w_wr_hs & w_wr_rw & ~r_busy;
  assign w_start     = w_wr_apply & (w_wr_idx == REG_CTRL) &
                       s_axil_wstrb[0] & s_axil_wdata[0];
  assign w_completion = dma_status_valid & dma_status;

  assign w_src_merged = f_merge(64'(r_src), s_axil_wdata, s_axil_wstrb);
  assign w_dst_merged = f_merge(64'(r_dst), s_axil_wdata, s_axil_wstrb);
  assign w_len_merged = f_merge(64'(r_len), s_axil_wdata, s_axil_wstrb);

  // ---------------------------------------------------------------------------
  // Write channel handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_awready <= w_wr_take;
      r_wready  <= w_wr_take;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_reject ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic        w_rd_hs;
  logic [63:0] w_rd_data;

  assign w_rd_hs = r_arready & s_axil_arvalid;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // output unassigned (which would infer a latch).
    w_rd_data = '0;
    case (reg_idx_e'(s_axil_araddr[5:3]))
      REG_CTRL:     w_rd_data = {61'd0, r_irq_en, r_dir, r_dma_start};
      REG_SRC:      w_rd_data = 64'(r_src);
      REG_DST:      w_rd_data = 64'(r_dst);
      REG_LEN:      w_rd_data = 64'(r_len);
      REG_STATUS:   w_rd_data = {62'd0, r_busy, r_done};
      REG_TX_LEN:   w_rd_data = 64'(r_tx_len);
      REG_DONE_CNT: w_rd_data = {32'd0, r_done_cnt};
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axil_arvalid & ~r_rvalid & ~r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file, command and completion tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_dma_start <= 1'b0;
      r_dir       <= 1'b0;
      r_irq_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_tx_len    <= '0;
      r_done_cnt  <= '0;
      r_done_irq  <= 1'b0;
    end else begin
      r_done_irq <= w_completion & r_irq_en;

      if (clear_dma_start) r_dma_start <= 1'b0;

      // Completion first: an accepted START in the same cycle (only possible
      // when idle) then overrides BUSY/DONE below.
      if (w_completion) begin
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_done_cnt <= r_done_cnt + 32'd1;
      end

      if (w_wr_apply) begin
        case (w_wr_idx)
          REG_CTRL: begin
            if (s_axil_wstrb[0]) begin
              r_dir    <= s_axil_wdata[1];
              r_irq_en <= s_axil_wdata[2];
            end
          end
          REG_SRC: r_src <= w_src_merged[VADDR_BITS-1:0];
          REG_DST: r_dst <= w_dst_merged[VADDR_BITS-1:0];
          REG_LEN: r_len <= w_len_merged[LEN_BITS-1:0];
          default: ;
        endcase
      end

      if (w_start) begin
        r_dma_start <= 1'b1;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
      end

      if (coyote_dma_tx_len_valid) r_tx_len <= coyote_dma_tx_len;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_arready = r_arready;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = RESP_OKAY;
  assign s_axil_rvalid  = r_rvalid;
  assign dma_start      = r_dma_start;
  assign dma_direction  = r_dir;
  assign dma_src_addr   = r_src;
  assign dma_dst_addr   = r_dst;
  assign dma_len        = r_len;
  assign done_irq       = r_done_irq;

  // Address bits outside [5:3] and merge bits above the register widths are
  // intentionally ignored.
  logic w_unused;
  assign w_unused = ^{s_axil_awaddr[AXIL_ADDR_BITS-1:6], s_axil_awaddr[2:0],
                      s_axil_araddr[AXIL_ADDR_BITS-1:6], s_axil_araddr[2:0],
                      w_src_merged[63:VADDR_BITS], w_dst_merged[63:VADDR_BITS],
                      w_len_merged[63:LEN_BITS]};

endmodule

// File: tb/tb_dma_csr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_csr_ctrl
//
// Directed bench for dma_csr_ctrl. A transaction-level model of the register
// file (plain variables updated per completed bus/engine event) supplies the
// expected register contents; a negedge compare process checks the engine-side
// outputs against it every cycle, and directed steps pin key values literally.
// -----------------------------------------------------------------------------
module tb_dma_csr_ctrl;

  localparam logic [63:0] SRC_MASK = 64'h0000_FFFF_FFFF_FFFF;
  localparam logic [63:0] LEN_MASK = 64'h0000_0000_0FFF_FFFF;

  logic        aclk;
  logic        aresetn;
  logic [15:0] awaddr;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [15:0] araddr;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        dma_start, dma_direction;
  logic [47:0] dma_src_addr, dma_dst_addr;
  logic [27:0] dma_len;
  logic        dma_status, dma_status_valid, clear_dma_start;
  logic        tx_len_valid;
  logic [27:0] tx_len;
  logic        done_irq;

  dma_csr_ctrl #(.VADDR_BITS(48), .LEN_BITS(28), .AXIL_ADDR_BITS(16)) dut (
    .aclk                    (aclk),
    .aresetn                 (aresetn),
    .s_axil_awaddr           (awaddr),
    .s_axil_awvalid          (awvalid),
    .s_axil_awready          (awready),
    .s_axil_wdata            (wdata),
    .s_axil_wstrb            (wstrb),
    .s_axil_wvalid           (wvalid),
    .s_axil_wready           (wready),
    .s_axil_bresp            (bresp),
    .s_axil_bvalid           (bvalid),
    .s_axil_bready           (bready),
    .s_axil_araddr           (araddr),
    .s_axil_arvalid          (arvalid),
    .s_axil_arready          (arready),
    .s_axil_rdata            (rdata),
    .s_axil_rresp            (rresp),
    .s_axil_rvalid           (rvalid),
    .s_axil_rready           (rready),
    .dma_start               (dma_start),
    .dma_direction           (dma_direction),
    .dma_src_addr            (dma_src_addr),
    .dma_dst_addr            (dma_dst_addr),
    .dma_len                 (dma_len),
    .dma_status              (dma_status),
    .dma_status_valid        (dma_status_valid),
    .clear_dma_start         (clear_dma_start),
    .coyote_dma_tx_len_valid (tx_len_valid),
    .coyote_dma_tx_len       (tx_len),
    .done_irq                (done_irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int irq_cyc = -1;   // cycle in which done_irq must be high
  int aw_hs   = 0;
  int ar_hs   = 0;

  always @(posedge aclk) begin
    cyc = cyc + 1;
    if (aresetn && awready && awvalid && wvalid) aw_hs = aw_hs + 1;
    if (aresetn && arready && arvalid) ar_hs = ar_hs + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Register-file model
  // ---------------------------------------------------------------------------
  logic        m_pending, m_dir, m_irq_en, m_busy, m_done;
  logic [63:0] m_src, m_dst, m_len, m_txlen;
  logic [31:0] m_cnt;
  logic [1:0]  wr_exp_resp;
  logic [63:0] rd_last;

  task automatic m_reset();
    m_pending = 0; m_dir = 0; m_irq_en = 0; m_busy = 0; m_done = 0;
    m_src = 0; m_dst = 0; m_len = 0; m_txlen = 0; m_cnt = 0; irq_cyc = -1;
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] v;
    v = old_v;
    for (int i = 0; i < 8; i++) if (s[i]) v[i*8 +: 8] = d[i*8 +: 8];
    return v;
  endfunction

  function automatic logic [63:0] m_read(input logic [15:0] addr);
    logic [2:0] idx;
    idx = addr[5:3];
    case (idx)
      3'd0: return {61'd0, m_irq_en, m_dir, m_pending};
      3'd1: return m_src;
      3'd2: return m_dst;
      3'd3: return m_len;
      3'd4: return {62'd0, m_busy, m_done};
      3'd5: return m_txlen;
      3'd6: return {32'd0, m_cnt};
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_write(input logic [15:0] addr, input logic [63:0] d, input logic [7:0] s,
                         output logic [1:0] resp);
    logic [2:0] idx;
    idx  = addr[5:3];
    resp = 2'b00;
    if (idx >= 3'd4) return;
    if (m_busy) begin
      resp = 2'b10;
      return;
    end
    case (idx)
      3'd0: if (s[0]) begin
        m_dir    = d[1];
        m_irq_en = d[2];
        if (d[0]) begin
          m_pending = 1; m_busy = 1; m_done = 0;
        end
      end
      3'd1: m_src = merge(m_src, d, s) & SRC_MASK;
      3'd2: m_dst = merge(m_dst, d, s) & SRC_MASK;
      default: m_len = merge(m_len, d, s) & LEN_MASK;
    endcase
  endtask

  task automatic m_complete();
    irq_cyc = m_irq_en ? cyc : -1;
    m_busy  = 0;
    m_done  = 1;
    m_cnt   = m_cnt + 32'd1;
  endtask

  // ---------------------------------------------------------------------------
  // Every-cycle compare of engine-facing outputs
  // ---------------------------------------------------------------------------
  always @(negedge aclk) begin
    if (!aresetn) begin
      check("outs_in_reset", 64'(|{awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                                   dma_start, dma_direction, dma_src_addr, dma_dst_addr,
                                   dma_len, done_irq}), 64'd0);
    end else begin
      check("dma_start",     64'(dma_start),     64'(m_pending));
      check("dma_direction", 64'(dma_direction), 64'(m_dir));
      check("dma_src_addr",  64'(dma_src_addr),  m_src);
      check("dma_dst_addr",  64'(dma_dst_addr),  m_dst);
      check("dma_len",       64'(dma_len),       m_len);
      check("done_irq",      64'(done_irq),      64'(cyc == irq_cyc));
      check("awready_eq_wready", 64'(awready),   64'(wready));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus / engine drivers (inputs change #1 after posedge)
  // ---------------------------------------------------------------------------
  task automatic wr_begin(input logic [15:0] addr, input logic [63:0] d, input logic [7:0] s,
                          input bit keep, input bit with_done);
    int guard;
    guard = 0;
    awaddr = addr; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 0;
    @(posedge aclk); #1;
    while (!awready && guard < 50) begin
      @(posedge aclk); #1;
      guard++;
    end
    if (!awready) begin
      check("wr_handshake_timeout", 64'd0, 64'd1);
      awvalid = 0; wvalid = 0;
      return;
    end
    if (with_done) begin dma_status_valid = 1; dma_status = 1; end
    @(posedge aclk); #1;
    m_write(addr, d, s, wr_exp_resp);
    if (with_done) begin
      dma_status_valid = 0; dma_status = 0;
      m_complete();
    end
    if (!keep) begin awvalid = 0; wvalid = 0; end
    check("bvalid_after_hs", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), 64'(wr_exp_resp));
  endtask

  task automatic wr_end(input int hold);
    repeat (hold) begin
      @(posedge aclk); #1;
      check("bvalid_held", 64'(bvalid), 64'd1);
      check("bresp_held", 64'(bresp), 64'(wr_exp_resp));
    end
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    check("bvalid_cleared", 64'(bvalid), 64'd0);
  endtask

  task automatic write(input logic [15:0] addr, input logic [63:0] d, input logic [7:0] s);
    wr_begin(addr, d, s, 0, 0);
    wr_end(0);
  endtask

  task automatic rd_begin(input logic [15:0] addr);
    int guard;
    guard = 0;
    araddr = addr; arvalid = 1; rready = 0;
    @(posedge aclk); #1;
    while (!arready && guard < 50) begin
      @(posedge aclk); #1;
      guard++;
    end
    if (!arready) begin
      check("rd_handshake_timeout", 64'd0, 64'd1);
      arvalid = 0;
      rd_last = 'x;
      return;
    end
    @(posedge aclk); #1;
    arvalid = 0;
    check("rvalid_after_hs", 64'(rvalid), 64'd1);
    check("rresp", 64'(rresp), 64'd0);
    rd_last = rdata;
  endtask

  task automatic rd_end(input int hold);
    repeat (hold) begin
      @(posedge aclk); #1;
      check("rvalid_held", 64'(rvalid), 64'd1);
      check("rdata_held", rdata, rd_last);
    end
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    check("rvalid_cleared", 64'(rvalid), 64'd0);
  endtask

  // Read, compare against the model, return the data for literal pinning.
  task automatic read(input logic [15:0] addr, input string name, output logic [63:0] d);
    logic [63:0] exp;
    exp = m_read(addr);
    rd_begin(addr);
    check(name, rd_last, exp);
    d = rd_last;
    rd_end(0);
  endtask

  task automatic clear_pulse();
    clear_dma_start = 1;
    @(posedge aclk); #1;
    clear_dma_start = 0;
    m_pending = 0;
  endtask

  task automatic complete(input bit with_tx, input logic [27:0] txl);
    dma_status_valid = 1; dma_status = 1; tx_len_valid = with_tx; tx_len = txl;
    @(posedge aclk); #1;
    dma_status_valid = 0; dma_status = 0; tx_len_valid = 0;
    m_complete();
    if (with_tx) m_txlen = 64'(txl);
  endtask

  task automatic ack();
    dma_status_valid = 1; dma_status = 0;
    @(posedge aclk); #1;
    dma_status_valid = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] d;
    int          hs_save;

    aresetn = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    dma_status = 0; dma_status_valid = 0; clear_dma_start = 0;
    tx_len_valid = 0; tx_len = 0;
    m_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk); aresetn = 1;
    @(posedge aclk); #1;

    // Reset state: every register reads 0 with OKAY.
    for (int i = 0; i < 8; i++) begin
      read(16'(i * 8), "reset_read", d);
      check("reset_read_lit", d, 64'd0);
    end

    // Program a device-to-host transfer.
    write(16'h08, 64'h1000, 8'hFF);
    write(16'h10, 64'h2000, 8'hFF);
    write(16'h18, 64'h100,  8'hFF);
    write(16'h00, 64'h3,    8'hFF);
    check("start_lit",   64'(dma_start),     64'd1);
    check("dir_lit",     64'(dma_direction), 64'd1);
    check("len_lit",     64'(dma_len),       64'h100);
    check("dst_lit",     64'(dma_dst_addr),  64'h2000);
    read(16'h20, "status_busy", d);
    check("status_busy_lit", d, 64'h2);
    read(16'h00, "ctrl_rb", d);
    check("ctrl_rb_lit", d, 64'h3);

    // Engine accepts, then completes with tx_len; IRQ disabled.
    clear_pulse();
    check("start_dropped_lit", 64'(dma_start), 64'd0);
    complete(1, 28'h100);
    check("irq_off_lit", 64'(done_irq), 64'd0);
    read(16'h20, "status_done", d);
    check("status_done_lit", d, 64'h1);
    read(16'h28, "tx_len", d);
    check("tx_len_lit", d, 64'h100);
    read(16'h30, "done_cnt1", d);
    check("done_cnt1_lit", d, 64'h1);

    // Writes to RO registers are dropped with OKAY.
    write(16'h20, 64'hFF, 8'hFF);
    check("ro_write_okay_lit", 64'(wr_exp_resp), 64'd0);
    read(16'h20, "status_after_ro_wr", d);

    // IRQ enabled; write while busy is rejected.
    write(16'h00, 64'h5, 8'hFF);
    ack();
    read(16'h20, "status_after_ack", d);
    check("status_after_ack_lit", d, 64'h2);
    wr_begin(16'h18, 64'h40, 8'hFF, 0, 0);
    check("slverr_lit", 64'(bresp), 64'h2);
    wr_end(0);
    read(16'h18, "len_kept", d);
    check("len_kept_lit", d, 64'h100);
    clear_pulse();
    complete(0, 28'h0);
    check("irq_hi_lit", 64'(done_irq), 64'd1);
    @(posedge aclk); #1;
    check("irq_lo_lit", 64'(done_irq), 64'd0);

    // Truncation on write, then back-pressure with pending requests.
    write(16'h08, 64'hABCD_1234_5678_9ABC, 8'hFF);
    read(16'h08, "src_trunc", d);
    check("src_trunc_lit", d, 64'h1234_5678_9ABC);

    rd_begin(16'h20);
    araddr = 16'h10; arvalid = 1;          // second read pending
    hs_save = ar_hs;
    rd_end(5);
    check("no_second_ar_hs", 64'(ar_hs), 64'(hs_save));
    rd_begin(16'h10);
    check("pending_read", rd_last, m_read(16'h10));
    rd_end(0);

    wr_begin(16'h08, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0F, 1, 0);
    awaddr = 16'h10; wdata = 64'h55; wstrb = 8'h01;   // second write pending
    hs_save = aw_hs;
    wr_end(5);
    check("no_second_aw_hs", 64'(aw_hs), 64'(hs_save));
    wr_begin(16'h10, 64'h55, 8'h01, 0, 0);
    wr_end(0);
    read(16'h08, "src_strb", d);
    check("src_strb_lit", d, 64'h1234_DEAD_BEEF);
    read(16'h10, "dst_strb", d);
    check("dst_strb_lit", d, 64'h2055);

    // Completion coincident with a rejected START write.
    write(16'h00, 64'h7, 8'hFF);
    wr_begin(16'h00, 64'h1, 8'h01, 0, 1);
    check("start_vs_done_slverr_lit", 64'(bresp), 64'h2);
    wr_end(0);
    read(16'h20, "status_coincident", d);
    check("status_coincident_lit", d, 64'h1);
    clear_pulse();

    // Completion coincident with a rejected LEN write.
    write(16'h00, 64'h7, 8'hFF);
    wr_begin(16'h18, 64'h77, 8'hFF, 0, 1);
    wr_end(0);
    read(16'h18, "len_coincident", d);
    check("len_coincident_lit", d, 64'h100);
    read(16'h30, "done_cnt4", d);
    check("done_cnt4_lit", d, 64'h4);
    clear_pulse();

    // Asynchronous reset while a command is pending.
    write(16'h00, 64'h3, 8'hFF);
    #2;
    aresetn = 0;
    #1;
    check("async_rst_start_lit", 64'(dma_start), 64'd0);
    check("async_rst_bvalid_lit", 64'(bvalid), 64'd0);
    check("async_rst_src_lit", 64'(dma_src_addr), 64'd0);
    m_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1;
    @(posedge aclk); #1;
    read(16'h20, "status_after_rst", d);
    check("status_after_rst_lit", d, 64'd0);
    read(16'h30, "cnt_after_rst", d);
    read(16'h08, "src_after_rst", d);

    repeat (2) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
